light_cycle_mover: RTL and testbench

LIGHT_CYCLE_MOVER -- requirements
Module: light_cycle_mover

---
 rtl/light_cycle_mover.sv | 119 +++++++++++
 tb/tb_light_cycle_mover.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/light_cycle_mover.sv
// Light-cycle position stepper: moves one pixel every TICK_DIV run clocks, x taking priority over y.
// Edge behaviour is selected by LIGHT_CYCLE_WRAP_EN (defined: wrap around, undefined: sticky crash).
module light_cycle_mover #(
   parameter int H_MAX    = 640,
   parameter int V_MAX    = 480,
   parameter int X_INIT   = 320,
   parameter int Y_INIT   = 240,
   parameter int TICK_DIV = 416667
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       onoffx,
   input  logic       onoffy,
   input  logic       horizontal,
   input  logic       verticle,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       step_valid,
   output logic       crash
);

   localparam int             CW       = $clog2(TICK_DIV);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [9:0]     X_LAST   = 10'(H_MAX - 1);
   localparam logic [9:0]     Y_LAST   = 10'(V_MAX - 1);
   localparam logic [9:0]     X_RST    = 10'(X_INIT);
   localparam logic [9:0]     Y_RST    = 10'(Y_INIT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [9:0]    x_q, x_d, y_q, y_d;
   logic          step_valid_q, step_valid_d;
   logic          crash_q, crash_d;
   logic [9:0]    x_mv, y_mv;
   logic          at_edge;

   // Candidate position for this step; at_edge flags a move off the playfield (x_mv/y_mv hold the wrapped value).
   always_comb begin
      x_mv    = x_q;
      y_mv    = y_q;
      at_edge = 1'b0;
      if (onoffx) begin
         if (horizontal) begin
            at_edge = (x_q == X_LAST);
            x_mv    = (x_q == X_LAST) ? 10'd0 : x_q + 10'd1;
         end else begin
            at_edge = (x_q == 10'd0);
            x_mv    = (x_q == 10'd0) ? X_LAST : x_q - 10'd1;
         end
      end else if (onoffy) begin
         if (verticle) begin
            at_edge = (y_q == Y_LAST);
            y_mv    = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
         end else begin
            at_edge = (y_q == 10'd0);
            y_mv    = (y_q == 10'd0) ? Y_LAST : y_q - 10'd1;
         end
      end else begin
         x_mv    = x_q;
         y_mv    = y_q;
         at_edge = 1'b0;
      end
   end

   // Tick counter and step decision; a crash freezes everything until reset.
   always_comb begin
      cnt_d        = cnt_q;
      x_d          = x_q;
      y_d          = y_q;
      step_valid_d = 1'b0;
      crash_d      = crash_q;
      if (run && !crash_q) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = {CW{1'b0}};
            if (at_edge) begin
`ifdef LIGHT_CYCLE_WRAP_EN
               x_d          = x_mv;
               y_d          = y_mv;
               step_valid_d = 1'b1;
`else
               crash_d      = 1'b1;
`endif
            end else begin
               x_d          = x_mv;
               y_d          = y_mv;
               step_valid_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q        <= {CW{1'b0}};
         x_q          <= X_RST;
         y_q          <= Y_RST;
         step_valid_q <= 1'b0;
         crash_q      <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         x_q          <= x_d;
         y_q          <= y_d;
         step_valid_q <= step_valid_d;
         crash_q      <= crash_d;
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign step_valid = step_valid_q;
   assign crash      = crash_q;

endmodule

// File: tb/tb_light_cycle_mover.sv
// Bench for light_cycle_mover: two instances (X_INIT 320 and 639) against an arithmetic position model.
// Build with LIGHT_CYCLE_WRAP_EN defined to exercise the wrap-around variant.
module tb_light_cycle_mover;
   localparam int TD = 4;
   localparam int H  = 640;
   localparam int V  = 480;
`ifdef LIGHT_CYCLE_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b0, run = 1'b0;
   logic onoffx = 1'b0, onoffy = 1'b0, horizontal = 1'b0, verticle = 1'b0;
   logic [9:0] x_a, y_a, x_b, y_b;
   logic sv_a, cr_a, sv_b, cr_b;

   int vectors = 0, miscompares = 0;
   bit chk_en = 1'b0;
   int mx[2], my[2], mcnt[2];
   bit msv[2], mcr[2];
   int xinit[2] = '{320, 639};

   light_cycle_mover #(.H_MAX(H), .V_MAX(V), .X_INIT(320), .Y_INIT(240), .TICK_DIV(TD)) dut_a (
      .clk(clk), .reset(reset), .run(run), .onoffx(onoffx), .onoffy(onoffy),
      .horizontal(horizontal), .verticle(verticle),
      .x(x_a), .y(y_a), .step_valid(sv_a), .crash(cr_a));

   light_cycle_mover #(.H_MAX(H), .V_MAX(V), .X_INIT(639), .Y_INIT(240), .TICK_DIV(TD)) dut_b (
      .clk(clk), .reset(reset), .run(run), .onoffx(onoffx), .onoffy(onoffy),
      .horizontal(horizontal), .verticle(verticle),
      .x(x_b), .y(y_b), .step_valid(sv_b), .crash(cr_b));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input int i);
      int nx, ny;
      nx = mx[i];
      ny = my[i];
      if (onoffx) nx += horizontal ? 1 : -1;
      else if (onoffy) ny += verticle ? 1 : -1;
      if (nx < 0 || nx >= H || ny < 0 || ny >= V) begin
         if (WRAP) begin
            mx[i] = (nx + H) % H;
            my[i] = (ny + V) % V;
            msv[i] = 1'b1;
         end else begin
            mcr[i] = 1'b1;
         end
      end else begin
         mx[i] = nx;
         my[i] = ny;
         msv[i] = 1'b1;
      end
   endtask

   // Behavioural model: position after each rising edge.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            mx[i] = xinit[i]; my[i] = 240; mcnt[i] = 0; msv[i] = 1'b0; mcr[i] = 1'b0;
         end else begin
            msv[i] = 1'b0;
            if (run && !mcr[i]) begin
               if (mcnt[i] == TD - 1) begin
                  mcnt[i] = 0;
                  model_step(i);
               end else begin
                  mcnt[i]++;
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_x_a", 32'(x_a), 32'(mx[0]));
         check("model_y_a", 32'(y_a), 32'(my[0]));
         check("model_sv_a", 32'(sv_a), 32'(msv[0]));
         check("model_crash_a", 32'(cr_a), 32'(mcr[0]));
         check("model_x_b", 32'(x_b), 32'(mx[1]));
         check("model_y_b", 32'(y_b), 32'(my[1]));
         check("model_sv_b", 32'(sv_b), 32'(msv[1]));
         check("model_crash_b", 32'(cr_b), 32'(mcr[1]));
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clks(1);
      reset = 1'b1;
   endtask

   initial begin
      int pulses;
      // Reset held with motion requested
      reset = 1'b0; run = 1'b1; onoffx = 1'b1;
      clks(2);
      chk_en = 1'b1;
      check("rst_x", 32'(x_a), 32'd320);
      check("rst_y", 32'(y_a), 32'd240);
      check("rst_crash", 32'(cr_a), 32'd0);
      check("rst_sv", 32'(sv_a), 32'd0);
      check("rst_x_b", 32'(x_b), 32'd639);

      // Step cadence moving right
      reset = 1'b1; horizontal = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 12; k++) begin
         clks(1);
         check("cadence_sv", 32'(sv_a), 32'((k % 4) == 0));
         if (sv_a === 1'b1) pulses++;
      end
      check("cadence_pulses", 32'(pulses), 32'd3);
      check("cadence_x", 32'(x_a), 32'd323);
      check("cadence_y", 32'(y_a), 32'd240);

      // x priority over y, then y alone
      do_reset();
      onoffy = 1'b1; verticle = 1'b0;
      clks(4);
      check("prio_x", 32'(x_a), 32'd321);
      check("prio_y", 32'(y_a), 32'd240);
      onoffx = 1'b0;
      clks(4);
      check("yonly_y", 32'(y_a), 32'd239);
      check("yonly_x", 32'(x_a), 32'd321);
      check("yonly_sv", 32'(sv_a), 32'd1);

      // Pause mid-count
      clks(2);
      run = 1'b0;
      for (int k = 0; k < 10; k++) begin
         clks(1);
         check("pause_sv", 32'(sv_a), 32'd0);
         check("pause_y", 32'(y_a), 32'd239);
      end
      run = 1'b1;
      clks(1);
      check("resume_sv0", 32'(sv_a), 32'd0);
      clks(1);
      check("resume_sv1", 32'(sv_a), 32'd1);
      check("resume_y", 32'(y_a), 32'd238);

      // Hold step: no direction still pulses
      do_reset();
      onoffx = 1'b0; onoffy = 1'b0;
      clks(4);
      check("hold_sv", 32'(sv_a), 32'd1);
      check("hold_x", 32'(x_a), 32'd320);
      check("hold_y", 32'(y_a), 32'd240);

      // Right edge on instance B
      do_reset();
      onoffx = 1'b1; horizontal = 1'b1;
      clks(3);
      check("redge_pre_x", 32'(x_b), 32'd639);
      clks(1);
      check("redge_x", 32'(x_b), WRAP ? 32'd0 : 32'd639);
      check("redge_sv", 32'(sv_b), 32'(WRAP));
      check("redge_crash", 32'(cr_b), 32'(!WRAP));
      for (int k = 0; k < 8; k++) begin
         clks(1);
         check("redge_crash_hold", 32'(cr_b), 32'(!WRAP));
      end

      // Reset mid-count while B is crashed
      clks(2);
      do_reset();
      check("rcrash_crash", 32'(cr_b), 32'd0);
      check("rcrash_x", 32'(x_b), 32'd639);
      for (int k = 1; k <= 3; k++) begin
         clks(1);
         check("rcrash_nostep", 32'(sv_a), 32'd0);
      end
      clks(1);
      check("rcrash_step_a", 32'(sv_a), 32'd1);
      check("rcrash_crash_b", 32'(cr_b), 32'(!WRAP));

      // Top edge
      do_reset();
      onoffx = 1'b0; onoffy = 1'b1; verticle = 1'b0;
      clks(240 * TD);
      check("top_y0", 32'(y_a), 32'd0);
      clks(TD);
      check("top_y", 32'(y_a), WRAP ? 32'd479 : 32'd0);
      check("top_crash", 32'(cr_a), 32'(!WRAP));

      // Bottom edge
      do_reset();
      verticle = 1'b1;
      clks(239 * TD);
      check("bot_y479", 32'(y_a), 32'd479);
      clks(TD);
      check("bot_y", 32'(y_a), WRAP ? 32'd0 : 32'd479);
      check("bot_crash", 32'(cr_a), 32'(!WRAP));

      // Left edge
      do_reset();
      onoffx = 1'b1; horizontal = 1'b0; onoffy = 1'b0;
      clks(320 * TD);
      check("left_x0", 32'(x_a), 32'd0);
      clks(TD);
      check("left_x", 32'(x_a), WRAP ? 32'd639 : 32'd0);
      check("left_crash", 32'(cr_a), 32'(!WRAP));
      clks(2);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
